// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing generator with four selectable test
// patterns (animated XOR gradient, colour bars, checkerboard, solid colour).
// Every output is registered and carries the pixel the counters held one
// pclk earlier, so all outputs stay mutually aligned.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned COLOR_W  = 5,
  parameter int unsigned CHK_LOG2 = 4,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic                   pclk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [HW-1:0]          x,
  output logic [VW-1:0]          y,
  output logic                   frame_start
);

  // Bar width; clamped to 1 so very narrow modes still elaborate.
  localparam int unsigned BAR_W_RAW = H_ACTIVE / 8;
  localparam int unsigned BAR_W     = (BAR_W_RAW == 0) ? 1 : BAR_W_RAW;
  localparam int unsigned BW        = $clog2(BAR_W + 1);

  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = VS_START + V_SYNC;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic          HS_ACT  = 1'(HS_POL);
  localparam logic          VS_ACT  = 1'(VS_POL);

  // Raster position and frame state
  logic [HW-1:0]          r_hc;
  logic [VW-1:0]          r_vc;
  logic [COLOR_W-1:0]     r_frame_cnt;
  logic [1:0]             r_mode_q;
  logic [3*COLOR_W-1:0]   r_solid_q;
  logic [BW-1:0]          r_bar_cnt;
  logic [2:0]             r_bar_idx;

  // Registered outputs
  logic [COLOR_W-1:0]     r_r;
  logic [COLOR_W-1:0]     r_g;
  logic [COLOR_W-1:0]     r_b;
  logic                   r_hs;
  logic                   r_vs;
  logic                   r_de;
  logic [HW-1:0]          r_x;
  logic [VW-1:0]          r_y;
  logic                   r_fs;

  // Decoded view of the current counter position
  logic                   w_h_last;
  logic                   w_v_last;
  logic                   w_origin;
  logic                   w_active;
  logic                   w_hs_on;
  logic                   w_vs_on;
  logic [1:0]             w_mode;
  logic [3*COLOR_W-1:0]   w_solid;
  logic                   w_chk;
  logic [COLOR_W-1:0]     w_r;
  logic [COLOR_W-1:0]     w_g;
  logic [COLOR_W-1:0]     w_b;

  assign w_h_last = (r_hc == H_LAST);
  assign w_v_last = (r_vc == V_LAST);
  assign w_origin = (r_hc == '0) && (r_vc == '0);
  assign w_active = (32'(r_hc) < H_ACTIVE) && (32'(r_vc) < V_ACTIVE);
  assign w_hs_on  = (32'(r_hc) >= HS_START) && (32'(r_hc) < HS_END);
  assign w_vs_on  = (32'(r_vc) >= VS_START) && (32'(r_vc) < VS_END);

  // Pixel (0,0) already uses the freshly sampled mode/colour.
  assign w_mode   = w_origin ? mode      : r_mode_q;
  assign w_solid  = w_origin ? solid_rgb : r_solid_q;

  assign w_chk    = 1'(r_hc >> CHK_LOG2) ^ 1'(r_vc >> CHK_LOG2);

  // Horizontal/vertical raster counters
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_last) begin
      r_hc <= '0;
      r_vc <= w_v_last ? '0 : r_vc + VW'(1);
    end else begin
      r_hc <= r_hc + HW'(1);
    end
  end

  // Bar sub-counter: index advances every BAR_W pixels and sticks at 7
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (w_h_last) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_cnt == BAR_LAST) begin
      r_bar_cnt <= '0;
      if (r_bar_idx != 3'd7) begin
        r_bar_idx <= r_bar_idx + 3'd1;
      end
    end else begin
      r_bar_cnt <= r_bar_cnt + BW'(1);
    end
  end

  // Frame counter animating the XOR gradient
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_h_last && w_v_last) begin
      r_frame_cnt <= r_frame_cnt + COLOR_W'(1);
    end
  end

  // Per-frame capture of pattern select and solid colour
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q  <= '0;
      r_solid_q <= '0;
    end else if (w_origin) begin
      r_mode_q  <= mode;
      r_solid_q <= solid_rgb;
    end
  end

  // Pattern colour for the current counter position
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_active) begin
      case (w_mode)
        2'd0: begin
          w_r = ~COLOR_W'(r_hc) ^ r_frame_cnt;
          w_g =  COLOR_W'(r_vc) ^ r_frame_cnt;
        end
        2'd1: begin
          w_r = {COLOR_W{~r_bar_idx[1]}};
          w_g = {COLOR_W{~r_bar_idx[2]}};
          w_b = {COLOR_W{~r_bar_idx[0]}};
        end
        2'd2: begin
          w_r = {COLOR_W{~w_chk}};
          w_g = {COLOR_W{~w_chk}};
          w_b = {COLOR_W{~w_chk}};
        end
        default: begin
          {w_r, w_g, w_b} = w_solid;
        end
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
      r_hs <= ~HS_ACT;
      r_vs <= ~VS_ACT;
      r_de <= 1'b0;
      r_x  <= '0;
      r_y  <= '0;
      r_fs <= 1'b0;
    end else begin
      r_r  <= w_r;
      r_g  <= w_g;
      r_b  <= w_b;
      r_hs <= w_hs_on ? HS_ACT : ~HS_ACT;
      r_vs <= w_vs_on ? VS_ACT : ~VS_ACT;
      r_de <= w_active;
      r_x  <= r_hc;
      r_y  <= r_vc;
      r_fs <= w_origin;
    end
  end

  assign r           = r_r;
  assign g           = r_g;
  assign b           = r_b;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: a scaled mode, a tiny mode and the default
// 800x600 mode run side by side from one reset. Expected pixels come from a
// raster model indexed by cycles since reset release.
module tb_vga_pattern_gen;

  // Scaled mode
  localparam int unsigned M_HA = 68, M_HF = 4, M_HS = 8, M_HB = 4;
  localparam int unsigned M_VA = 20, M_VF = 1, M_VS = 2, M_VB = 3;
  localparam int unsigned M_HT = M_HA + M_HF + M_HS + M_HB;
  localparam int unsigned M_VT = M_VA + M_VF + M_VS + M_VB;
  localparam int unsigned M_FT = M_HT * M_VT;
  localparam int unsigned M_BARW = M_HA / 8;
  localparam int unsigned M_CHK = 2;
  // Tiny mode (active-high syncs)
  localparam int unsigned S_HT = 12, S_VT = 7, S_FT = S_HT * S_VT;
  // Default mode
  localparam int unsigned D_HT = 1056;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]  mode_m = 2'd0;
  logic [14:0] solid_m = 15'd0;
  logic [1:0]  mode_s = 2'd2;
  logic [1:0]  mode_d = 2'd0;
  logic [14:0] solid_z = 15'd0;

  logic [4:0] m_r, m_g, m_b, s_r, s_g, s_b, d_r, d_g, d_b;
  logic m_hs, m_vs, m_de, m_fs, s_hs, s_vs, s_de, s_fs, d_hs, d_vs, d_de, d_fs;
  logic [6:0] m_x;
  logic [4:0] m_y;
  logic [3:0] s_x;
  logic [2:0] s_y;
  logic [10:0] d_x;
  logic [9:0] d_y;

  int errors = 0;
  int checks = 0;
  int unsigned k;
  logic [1:0]  fr_mode [64];
  logic [14:0] fr_solid[64];

  always #5 pclk = ~pclk;

  vga_pattern_gen #(
    .H_ACTIVE(M_HA), .H_FP(M_HF), .H_SYNC(M_HS), .H_BP(M_HB),
    .V_ACTIVE(M_VA), .V_FP(M_VF), .V_SYNC(M_VS), .V_BP(M_VB),
    .HS_POL(0), .VS_POL(0), .COLOR_W(5), .CHK_LOG2(M_CHK)
  ) u_med (
    .pclk(pclk), .rst_n(rst_n), .mode(mode_m), .solid_rgb(solid_m),
    .r(m_r), .g(m_g), .b(m_b), .hsync(m_hs), .vsync(m_vs), .de(m_de),
    .x(m_x), .y(m_y), .frame_start(m_fs)
  );

  vga_pattern_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .COLOR_W(5), .CHK_LOG2(1)
  ) u_small (
    .pclk(pclk), .rst_n(rst_n), .mode(mode_s), .solid_rgb(solid_z),
    .r(s_r), .g(s_g), .b(s_b), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .x(s_x), .y(s_y), .frame_start(s_fs)
  );

  vga_pattern_gen u_def (
    .pclk(pclk), .rst_n(rst_n), .mode(mode_d), .solid_rgb(solid_z),
    .r(d_r), .g(d_g), .b(d_b), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .x(d_x), .y(d_y), .frame_start(d_fs)
  );

  // Edges since reset release; edge k delivers raster pixel k-1
  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Remember what was driven on the first pixel of each scaled-mode frame
  always @(posedge pclk) begin
    if (rst_n && (k % M_FT) == 0) begin
      fr_mode[6'(k / M_FT)]  <= mode_m;
      fr_solid[6'(k / M_FT)] <= solid_m;
    end
  end

  function automatic logic [14:0] pix(input int unsigned xx, input int unsigned yy,
                                      input int unsigned fc, input logic [1:0] md,
                                      input logic [14:0] sol, input int unsigned barw,
                                      input int unsigned chk);
    int unsigned i, rr, gg, bb;
    rr = 0; gg = 0; bb = 0;
    case (md)
      2'd0: begin
        rr = (31 - (xx % 32)) ^ fc;
        gg = (yy % 32) ^ fc;
      end
      2'd1: begin
        i = xx / barw;
        if (i > 7) i = 7;
        rr = ((i & 2) != 0) ? 0 : 31;
        gg = ((i & 4) != 0) ? 0 : 31;
        bb = ((i & 1) != 0) ? 0 : 31;
      end
      2'd2: begin
        rr = ((((xx >> chk) ^ (yy >> chk)) & 1) != 0) ? 0 : 31;
        gg = rr;
        bb = rr;
      end
      default: return sol;
    endcase
    return {5'(rr), 5'(gg), 5'(bb)};
  endfunction

  function automatic logic [30:0] exp_m(input int unsigned kk);
    int unsigned p, xx, yy, f;
    logic [14:0] rgb;
    logic hs, vs, dd;
    if (kk == 0) return {15'd0, 1'b1, 1'b1, 1'b0, 7'd0, 5'd0, 1'b0};
    p  = (kk - 1) % M_FT;
    xx = p % M_HT;
    yy = p / M_HT;
    f  = (kk - 1) / M_FT;
    dd = (xx < M_HA) && (yy < M_VA);
    hs = !((xx >= M_HA + M_HF) && (xx < M_HA + M_HF + M_HS));
    vs = !((yy >= M_VA + M_VF) && (yy < M_VA + M_VF + M_VS));
    rgb = dd ? pix(xx, yy, f % 32, fr_mode[6'(f)], fr_solid[6'(f)], M_BARW, M_CHK) : 15'd0;
    return {rgb, hs, vs, dd, 7'(xx), 5'(yy), (p == 0)};
  endfunction

  function automatic logic [25:0] exp_s(input int unsigned kk);
    int unsigned p, xx, yy;
    logic [14:0] rgb;
    logic hs, vs, dd;
    if (kk == 0) return 26'd0;
    p  = (kk - 1) % S_FT;
    xx = p % S_HT;
    yy = p / S_HT;
    dd = (xx < 8) && (yy < 4);
    hs = (xx >= 9) && (xx < 11);
    vs = (yy == 5);
    rgb = dd ? pix(xx, yy, 0, 2'd2, 15'd0, 1, 1) : 15'd0;
    return {rgb, hs, vs, dd, 4'(xx), 3'(yy), (p == 0)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge pclk);
    checks++;
    if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(0)) begin
      errors++; $display("FAIL reset_med got=%h exp=%h", {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(0));
    end
    checks++;
    if ({s_r, s_g, s_b, s_hs, s_vs, s_de, s_x, s_y, s_fs} !== exp_s(0)) begin
      errors++; $display("FAIL reset_small got=%h exp=%h", {s_r, s_g, s_b, s_hs, s_vs, s_de, s_x, s_y, s_fs}, exp_s(0));
    end
    checks++;
    if ({d_de, d_fs, d_hs, d_vs, d_x, d_y, d_r, d_g, d_b} !== {1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 10'd0, 15'd0}) begin
      errors++; $display("FAIL reset_def got=%h", {d_de, d_fs, d_hs, d_vs, d_x, d_y, d_r, d_g, d_b});
    end
  endtask

  task automatic test_release();
    rst_n = 1'b1;
    @(negedge pclk);
    checks++;
    if ({m_fs, m_de, m_x, m_y, m_r, m_g, m_b} !== {1'b1, 1'b1, 7'd0, 5'd0, 5'd31, 5'd0, 5'd0}) begin
      errors++; $display("FAIL release_med got=%h", {m_fs, m_de, m_x, m_y, m_r, m_g, m_b});
    end
    checks++;
    if ({d_fs, d_de, d_x, d_y, d_r, d_g} !== {1'b1, 1'b1, 11'd0, 10'd0, 5'd31, 5'd0}) begin
      errors++; $display("FAIL release_def got=%h", {d_fs, d_de, d_x, d_y, d_r, d_g});
    end
    checks++;
    if ({s_fs, s_r, s_g, s_b} !== {1'b1, 15'h7fff}) begin
      errors++; $display("FAIL release_small got=%h exp=%h", {s_fs, s_r, s_g, s_b}, {1'b1, 15'h7fff});
    end
  endtask

  // Default mode: line-0 hsync run, blanking at x=800, pixel (5,3)
  task automatic test_default_lines();
    int unsigned p, xx, yy;
    int hs_first, hs_cnt;
    hs_first = -1; hs_cnt = 0;
    for (int c = 0; c < 3 * D_HT + 5; c++) begin
      @(negedge pclk);
      p = k - 1; xx = p % D_HT; yy = p / D_HT;
      if (yy == 0 && d_hs == 1'b0) begin
        if (hs_cnt == 0) hs_first = int'(xx);
        hs_cnt++;
      end
      if (yy == 0 && xx == 800) begin
        checks++;
        if ({d_de, d_r, d_g, d_b} !== 16'd0) begin
          errors++; $display("FAIL def_blank got=%h exp=0", {d_de, d_r, d_g, d_b});
        end
      end
      checks++;
      if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(k)) begin
        errors++; $display("FAIL def_lines_med k=%0d got=%h exp=%h", k, {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(k));
      end
    end
    checks++;
    if (hs_first != 840 || hs_cnt != 128) begin
      errors++; $display("FAIL def_hsync first=%0d cnt=%0d exp 840/128", hs_first, hs_cnt);
    end
    checks++;
    if ({d_x, d_y, d_r, d_g, d_b} !== {11'd5, 10'd3, 5'd26, 5'd3, 5'd0}) begin
      errors++; $display("FAIL def_px53 got x=%0d y=%0d r=%0d g=%0d b=%0d exp 5/3/26/3/0", d_x, d_y, d_r, d_g, d_b);
    end
  endtask

  // Two frames of gradient: full compare plus per-frame event totals
  task automatic test_mode0_frames();
    int unsigned last_fs;
    int n_hs, n_vs, n_de, n_fs;
    last_fs = 0; n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0;
    mode_m = 2'd0;
    for (int c = 0; c < 2 * M_FT; c++) begin
      @(negedge pclk);
      checks++;
      if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(k)) begin
        errors++; $display("FAIL mode0_vec k=%0d got=%h exp=%h", k, {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(k));
      end
      if (!m_hs) n_hs++;
      if (!m_vs) n_vs++;
      if (m_de) n_de++;
      if (m_fs) begin
        n_fs++;
        if (last_fs != 0) begin
          checks++;
          if (k - last_fs != M_FT) begin
            errors++; $display("FAIL fs_period got=%0d exp=%0d", k - last_fs, M_FT);
          end
        end
        last_fs = k;
      end
    end
    checks++;
    if (n_hs != 2 * M_VT * M_HS || n_vs != 2 * M_VS * M_HT || n_de != 2 * M_HA * M_VA || n_fs != 2) begin
      errors++; $display("FAIL mode0_counts got hs=%0d vs=%0d de=%0d fs=%0d exp %0d/%0d/%0d/2",
                         n_hs, n_vs, n_de, n_fs, 2 * M_VT * M_HS, 2 * M_VS * M_HT, 2 * M_HA * M_VA);
    end
  endtask

  task automatic test_bars();
    int n_wait, changes;
    bit found;
    logic [14:0] prev;
    n_wait = int'($urandom_range(100, 1500));
    for (int c = 0; c < n_wait; c++) begin
      @(negedge pclk);
      checks++;
      if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(k)) begin
        errors++; $display("FAIL bars_pre k=%0d got=%h exp=%h", k, {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(k));
      end
    end
    mode_m = 2'd1;
    found = 1'b0;
    for (int c = 0; c < M_FT + 2 && !found; c++) begin
      @(negedge pclk);
      checks++;
      if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(k)) begin
        errors++; $display("FAIL bars_tail k=%0d got=%h exp=%h", k, {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(k));
      end
      if (m_fs) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL bars_wait got no frame_start exp one within %0d", M_FT + 2);
    end
    changes = 0; prev = 15'h7fff;
    for (int c = 0; c < M_HT; c++) begin
      if (c > 0) @(negedge pclk);
      checks++;
      if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(k)) begin
        errors++; $display("FAIL bars_vec k=%0d got=%h exp=%h", k, {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(k));
      end
      if (m_x == 7'd0 || m_x == 7'd8 || m_x == 7'd67) begin
        checks++;
        if ({m_r, m_g, m_b} !== ((m_x == 7'd0) ? 15'h7fff : (m_x == 7'd8) ? 15'h7fe0 : 15'h0000)) begin
          errors++; $display("FAIL bars_edge x=%0d got=%h", m_x, {m_r, m_g, m_b});
        end
      end
      if (m_de && c > 0 && {m_r, m_g, m_b} != prev) changes++;
      if (m_de) prev = {m_r, m_g, m_b};
    end
    checks++;
    if (changes != 7) begin
      errors++; $display("FAIL bars_changes got=%0d exp=7", changes);
    end
  endtask

  // Mid-frame switch 0 -> 3 only takes effect at the next frame start
  task automatic test_mode_switch();
    int n_wait;
    bit found;
    mode_m = 2'd0;
    for (int pass = 0; pass < 2; pass++) begin
      found = 1'b0;
      for (int c = 0; c < M_FT + 2 && !found; c++) begin
        @(negedge pclk);
        checks++;
        if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(k)) begin
          errors++; $display("FAIL sw_vec k=%0d got=%h exp=%h", k, {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(k));
        end
        if (m_fs) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL sw_wait got no frame_start exp one");
      end
      if (pass == 0) begin
        n_wait = int'($urandom_range(200, 1800));
        for (int c = 0; c < n_wait; c++) begin
          @(negedge pclk);
          checks++;
          if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(k)) begin
            errors++; $display("FAIL sw_mid k=%0d got=%h exp=%h", k, {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(k));
          end
        end
        mode_m = 2'd3;
        solid_m = {5'd1, 5'd2, 5'd3};
      end
    end
    for (int c = 0; c < M_FT; c++) begin
      if (c > 0) @(negedge pclk);
      checks++;
      if ({m_r, m_g, m_b} !== (m_de ? {5'd1, 5'd2, 5'd3} : 15'd0)) begin
        errors++; $display("FAIL sw_solid x=%0d y=%0d got=%h exp=%h", m_x, m_y, {m_r, m_g, m_b}, m_de ? {5'd1, 5'd2, 5'd3} : 15'd0);
      end
    end
  endtask

  task automatic test_small_checker();
    bit found;
    int n_hs, n_vs;
    found = 1'b0; n_hs = 0; n_vs = 0;
    for (int c = 0; c < S_FT + 2 && !found; c++) begin
      @(negedge pclk);
      if (s_fs) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL small_wait got no frame_start exp one");
    end
    for (int c = 0; c < S_FT; c++) begin
      if (c > 0) @(negedge pclk);
      checks++;
      if ({s_r, s_g, s_b, s_hs, s_vs, s_de, s_x, s_y, s_fs} !== exp_s(k)) begin
        errors++; $display("FAIL small_vec k=%0d got=%h exp=%h", k, {s_r, s_g, s_b, s_hs, s_vs, s_de, s_x, s_y, s_fs}, exp_s(k));
      end
      if (s_y == 3'd0 && (s_x == 4'd0 || s_x == 4'd2)) begin
        checks++;
        if ({s_r, s_g, s_b} !== ((s_x == 4'd0) ? 15'h7fff : 15'h0000)) begin
          errors++; $display("FAIL small_chk x=%0d got=%h", s_x, {s_r, s_g, s_b});
        end
      end
      if (s_hs) n_hs++;
      if (s_vs) begin
        n_vs++;
        checks++;
        if (s_y !== 3'd5) begin
          errors++; $display("FAIL small_vs_line got=%0d exp=5", s_y);
        end
      end
    end
    checks++;
    if (n_hs != 2 * S_VT || n_vs != S_HT) begin
      errors++; $display("FAIL small_sync_counts got hs=%0d vs=%0d exp %0d/%0d", n_hs, n_vs, 2 * S_VT, S_HT);
    end
  endtask

  task automatic test_random_modes();
    for (int c = 0; c < 3 * M_FT; c++) begin
      @(negedge pclk);
      checks++;
      if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(k)) begin
        errors++; $display("FAIL rand_vec k=%0d got=%h exp=%h", k, {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(k));
      end
      if (($urandom % 400) == 0) begin
        mode_m  = 2'($urandom);
        solid_m = 15'($urandom);
      end
    end
  endtask

  // Asynchronous reset pulse part-way down the frame
  task automatic test_reset_midframe();
    bit found;
    mode_m = 2'd0;
    found = 1'b0;
    for (int c = 0; c < 2 * M_FT + 2 && !found; c++) begin
      @(negedge pclk);
      checks++;
      if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(k)) begin
        errors++; $display("FAIL rst_pre k=%0d got=%h exp=%h", k, {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(k));
      end
      if (m_y == 5'd10 && (k - 1) >= M_FT) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rst_wait got no line 10 exp one");
    end
    repeat ($urandom_range(0, 60)) @(negedge pclk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== {15'd0, 1'b1, 1'b1, 1'b0, 7'd0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL rst_async_med got=%h", {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs});
    end
    checks++;
    if ({s_r, s_g, s_b, s_hs, s_vs, s_de, s_x, s_y, s_fs} !== 26'd0) begin
      errors++; $display("FAIL rst_async_small got=%h exp=0", {s_r, s_g, s_b, s_hs, s_vs, s_de, s_x, s_y, s_fs});
    end
    repeat (2) @(negedge pclk);
    checks++;
    if ({d_de, d_fs, d_hs, d_vs, d_x, d_y, d_r} !== {1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 10'd0, 5'd0}) begin
      errors++; $display("FAIL rst_hold_def got=%h", {d_de, d_fs, d_hs, d_vs, d_x, d_y, d_r});
    end
    rst_n = 1'b1;
    @(negedge pclk);
    checks++;
    if ({m_fs, m_de, m_x, m_y, m_r, m_g, m_b} !== {1'b1, 1'b1, 7'd0, 5'd0, 5'd31, 5'd0, 5'd0}) begin
      errors++; $display("FAIL rst_restart_med got=%h", {m_fs, m_de, m_x, m_y, m_r, m_g, m_b});
    end
    checks++;
    if ({d_fs, d_x, d_y, d_r, d_g} !== {1'b1, 11'd0, 10'd0, 5'd31, 5'd0}) begin
      errors++; $display("FAIL rst_restart_def got=%h", {d_fs, d_x, d_y, d_r, d_g});
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge pclk);
      checks++;
      if ({m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs} !== exp_m(k)) begin
        errors++; $display("FAIL rst_post k=%0d got=%h exp=%h", k, {m_r, m_g, m_b, m_hs, m_vs, m_de, m_x, m_y, m_fs}, exp_m(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_default_lines();
    test_mode0_frames();
    test_bars();
    test_mode_switch();
    test_small_checker();
    test_random_modes();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
